// File: rtl/adc_config_sequencer.sv
// Host-side sequencer for the ADC control block: queues 24-bit register writes and replays
// them as control-code phases held for whole ADC_SCLK periods, with optional reset and SYNC.
module adc_config_sequencer #(
   parameter int SCLK_DIV    = 25,
   parameter int FIFO_DEPTH  = 16,
   parameter int RST_TICKS   = 8,
   parameter int BUF_TICKS   = 2,
   parameter int ISSUE_TICKS = 28,
   parameter int SYNC_TICKS  = 4,
   parameter int GAP_TICKS   = 2
) (
   input  logic        sys_clk,
   input  logic        iResetn,
   input  logic [23:0] iCmdData,
   input  logic        iCmdValid,
   output logic        oCmdReady,
   input  logic        iStart,
   input  logic        iDoReset,
   input  logic        iDoSync,
   input  logic        iAbort,
   output logic        oBusy,
   output logic        oDone,
   output logic [7:0]  oCount,
   output logic [7:0]  adc_control_comm,
   output logic [23:0] adc_serial_cmd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_RESET, S_GAP_R, S_LOAD, S_BUFFER, S_ISSUE, S_GAP_C, S_SYNC, S_FINAL
   } state_t;

   function automatic logic [7:0] code_of(input state_t s);
      case (s)
         S_RESET:  code_of = 8'hFF;
         S_BUFFER: code_of = 8'h01;
         S_ISSUE:  code_of = 8'h02;
         S_SYNC:   code_of = 8'h04;
         default:  code_of = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] ticks_of(input state_t s);
      case (s)
         S_RESET:                   ticks_of = 8'(RST_TICKS);
         S_BUFFER:                  ticks_of = 8'(BUF_TICKS);
         S_ISSUE:                   ticks_of = 8'(ISSUE_TICKS);
         S_SYNC:                    ticks_of = 8'(SYNC_TICKS);
         S_GAP_R, S_GAP_C, S_FINAL: ticks_of = 8'(GAP_TICKS);
         default:                   ticks_of = 8'd0;
      endcase
   endfunction

   // Shared "what comes next" decision after IDLE, GAP_R and GAP_C.
   function automatic state_t next_work(input logic avail, input logic sync);
      if (avail)     next_work = S_LOAD;
      else if (sync) next_work = S_SYNC;
      else           next_work = S_FINAL;
   endfunction

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_tick_cnt;
   logic [7:0]    r_phase, r_code, r_count;
   logic [23:0]   r_cmd;
   logic          r_done, r_do_sync;
   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wr_ptr, r_rd_ptr;
   logic          w_tick, w_exit, w_empty, w_full, w_push, w_pop, w_avail, w_start;

   assign w_tick  = (r_tick_cnt == TW'(SCLK_DIV - 1));
   assign w_exit  = w_tick && (r_phase == 8'd1);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = iCmdValid && !w_full;
   assign w_pop   = (r_state == S_LOAD) && !iAbort;
   // A word being pushed this cycle counts, so a push on the last gap cycle is not lost.
   assign w_avail = !w_empty || w_push;
   assign w_start = (r_state == S_IDLE) && iStart && !iAbort;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or negedge iResetn) begin
      if (!iResetn)    r_tick_cnt <= '0;
      else if (w_tick) r_tick_cnt <= '0;
      else             r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   // NOTE: FIFO storage is deliberately not reset; the pointers alone define valid contents.
   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= iCmdData;
   end

   always_ff @(posedge sys_clk or negedge iResetn) begin
      if (!iResetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_nxt = iDoReset ? S_RESET : next_work(w_avail, iDoSync);
         S_RESET:  if (w_exit) w_state_nxt = S_GAP_R;
         S_GAP_R:  if (w_exit) w_state_nxt = next_work(w_avail, r_do_sync);
         S_LOAD:   w_state_nxt = S_BUFFER;
         S_BUFFER: if (w_exit) w_state_nxt = S_ISSUE;
         S_ISSUE:  if (w_exit) w_state_nxt = S_GAP_C;
         S_GAP_C:  if (w_exit) w_state_nxt = next_work(w_avail, r_do_sync);
         S_SYNC:   if (w_exit) w_state_nxt = S_FINAL;
         S_FINAL:  if (w_exit) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (iAbort && (r_state != S_IDLE) && (r_state != S_FINAL)) w_state_nxt = S_FINAL;
   end

   // Codes are registered from the next state, so they move exactly on state entry.
   always_ff @(posedge sys_clk or negedge iResetn) begin
      if (!iResetn) begin
         r_state   <= S_IDLE;
         r_phase   <= 8'd0;
         r_code    <= 8'h00;
         r_cmd     <= 24'd0;
         r_count   <= 8'd0;
         r_done    <= 1'b0;
         r_do_sync <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= code_of(w_state_nxt);
         r_done  <= (r_state == S_FINAL) && (w_state_nxt == S_IDLE);
         if (w_state_nxt != r_state)      r_phase <= ticks_of(w_state_nxt);
         else if (w_tick && r_phase != 0) r_phase <= r_phase - 8'd1;
         if (w_start) begin
            r_do_sync <= iDoSync;
            r_count   <= 8'd0;
         end else if (r_state == S_ISSUE && w_state_nxt == S_GAP_C && r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
         end
         if (w_pop) r_cmd <= r_mem[r_rd_ptr[AW-1:0]];
      end
   end

   assign oCmdReady        = !w_full;
   assign oBusy            = (r_state != S_IDLE);
   assign oDone            = r_done;
   assign oCount           = r_count;
   assign adc_control_comm = r_code;
   assign adc_serial_cmd   = r_cmd;

endmodule
